// File: rtl/button_conditioner.sv
// Debounces a synchronized pushbutton level and derives press, release,
// long-press (held) and auto-repeat events from the debounced level.
module button_conditioner #(
  parameter int DEBOUNCE = 650000,
  parameter int HOLD     = 32500000,
  parameter int REPEAT   = 6500000,
  parameter int W        = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic clean,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    RPT  = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   dcnt_reg, dcnt_next;
  logic [W-1:0]   hcnt_reg, hcnt_next;
  logic           clean_reg, clean_next;
  logic           press_reg, press_next;
  logic           release_reg, release_next;
  logic           repeat_reg, repeat_next;
  logic           held_reg, held_next;
  logic           rise, fall;

  // Any cycle where in matches clean restarts the debounce window.
  always_comb begin
    dcnt_next  = '0;
    clean_next = clean_reg;
    if (in != clean_reg) begin
      if (dcnt_reg == W'(DEBOUNCE - 1))
        clean_next = in;
      else
        dcnt_next = dcnt_reg + 1'b1;
    end
  end

  // The FSM reacts on the same edge that updates clean.
  assign rise = clean_next & ~clean_reg;
  assign fall = ~clean_next & clean_reg;

  always_comb begin
    state_next   = state_reg;
    hcnt_next    = hcnt_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    repeat_next  = 1'b0;
    held_next    = held_reg;
    case (state_reg)
      IDLE: begin
        if (rise) begin
          press_next = 1'b1;
          hcnt_next  = '0;
          state_next = DOWN;
        end
      end
      DOWN: begin
        if (fall) begin
          release_next = 1'b1;
          held_next    = 1'b0;
          hcnt_next    = '0;
          state_next   = IDLE;
        end else if (hcnt_reg == W'(HOLD - 1)) begin
          repeat_next = 1'b1;
          held_next   = 1'b1;
          hcnt_next   = '0;
          state_next  = RPT;
        end else begin
          hcnt_next = hcnt_reg + 1'b1;
        end
      end
      RPT: begin
        // Release wins over a repeat that would land on the same edge.
        if (fall) begin
          release_next = 1'b1;
          held_next    = 1'b0;
          hcnt_next    = '0;
          state_next   = IDLE;
        end else if (hcnt_reg == W'(REPEAT - 1)) begin
          repeat_next = 1'b1;
          hcnt_next   = '0;
        end else begin
          hcnt_next = hcnt_reg + 1'b1;
        end
      end
      default: begin
        held_next  = 1'b0;
        hcnt_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      dcnt_reg    <= '0;
      hcnt_reg    <= '0;
      clean_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      repeat_reg  <= 1'b0;
      held_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dcnt_reg    <= dcnt_next;
      hcnt_reg    <= hcnt_next;
      clean_reg   <= clean_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      repeat_reg  <= repeat_next;
      held_reg    <= held_next;
    end
  end

  assign clean         = clean_reg;
  assign press         = press_reg;
  assign release_pulse = release_reg;
  assign repeat_pulse  = repeat_reg;
  assign held          = held_reg;

endmodule
